fmt_chan_bank: RTL and testbench

Multi-channel, parametrised tester pin-format driver. It replaces one double-buffered format register per pin with a bank of `NCH` channels that share one cycle counter and one set of edge timings. Each channel has its own double-buffered data bit, format code and leading-edge select, written through a single write port. Staged values move to the active set together, only at a test-cycle boundary. The bank sits between the test-vector sequencer (writes, swap requests) and the DUT pin drivers (`Q`).

---
 rtl/fmt_chan_bank.sv | 161 ++++++++++++++++
 tb/tb_fmt_chan_bank.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/fmt_chan_bank.sv
// Tester pin-format bank: NCH channels share one test-cycle counter and one set of
// edge timings; each channel double-buffers {d, fmt, esel} and swaps at a boundary.

module fmt_chan_lane #(
    parameter int TW = 10
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_en,
    input  logic [TW-1:0] i_cnt,
    input  logic [TW-1:0] i_cyc_len,
    input  logic [TW-1:0] i_lead_a,
    input  logic [TW-1:0] i_lead_b,
    input  logic [TW-1:0] i_trail,
    input  logic          i_wr,
    input  logic          i_wr_d,
    input  logic [1:0]    i_wr_fmt,
    input  logic          i_wr_esel,
    input  logic          i_swap,
    output logic          o_q
);
    typedef enum logic [1:0] {
        F_NRZ  = 2'b00,
        F_RZ   = 2'b01,
        F_R1   = 2'b10,
        F_DNRZ = 2'b11
    } fmt_e;

    logic          r_stg_d, r_stg_esel;
    fmt_e          r_stg_fmt;
    logic          r_act_d, r_act_esel;
    fmt_e          r_act_fmt;
    logic          r_hold, r_q;
    logic [TW-1:0] w_lead;
    logic          w_lead_ok, w_win, w_at_lead, w_q_nxt, w_hold_nxt;

    // A leading edge at or beyond the cycle length can never be reached by cnt,
    // so it disables both the window and the DNRZ capture.
    assign w_lead    = r_act_esel ? i_lead_b : i_lead_a;
    assign w_lead_ok = (w_lead < i_cyc_len);
    assign w_win     = w_lead_ok && (w_lead <= i_cnt) && (i_cnt < i_trail);
    assign w_at_lead = w_lead_ok && (i_cnt == w_lead);

    always_comb begin
        w_q_nxt    = 1'b0;
        w_hold_nxt = r_hold;
        if (i_en) begin
            case (r_act_fmt)
                F_RZ:    w_q_nxt = r_act_d & w_win;
                F_R1:    w_q_nxt = r_act_d | ~w_win;
                F_DNRZ: begin
                    if (w_at_lead) w_hold_nxt = r_act_d;
                    w_q_nxt = w_hold_nxt;
                end
                default: w_q_nxt = r_act_d;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_stg_d    <= 1'b0;
            r_stg_fmt  <= F_NRZ;
            r_stg_esel <= 1'b0;
            r_act_d    <= 1'b0;
            r_act_fmt  <= F_NRZ;
            r_act_esel <= 1'b0;
            r_hold     <= 1'b0;
            r_q        <= 1'b0;
        end else begin
            if (i_wr) begin
                r_stg_d    <= i_wr_d;
                r_stg_fmt  <= fmt_e'(i_wr_fmt);
                r_stg_esel <= i_wr_esel;
            end
            // Swap reads the pre-edge stage, so a same-edge write stays staged.
            if (i_swap) begin
                r_act_d    <= r_stg_d;
                r_act_fmt  <= r_stg_fmt;
                r_act_esel <= r_stg_esel;
            end
            r_hold <= w_hold_nxt;
            r_q    <= w_q_nxt;
        end
    end

    assign o_q = r_q;
endmodule

module fmt_chan_bank #(
    parameter int NCH = 8,
    parameter int TW  = 10,
    parameter int CHW = 3
) (
    input  logic           CLK,
    input  logic           RST_N,
    input  logic           EN,
    input  logic [TW-1:0]  CYCLE_LENGTH,
    input  logic [TW-1:0]  LEAD_A,
    input  logic [TW-1:0]  LEAD_B,
    input  logic [TW-1:0]  TRAIL,
    input  logic           WR_EN,
    input  logic [CHW-1:0] WR_CH,
    input  logic           WR_D,
    input  logic [1:0]     WR_FMT,
    input  logic           WR_ESEL,
    input  logic           SWAP_REQ,
    output logic           SWAP_PEND,
    output logic           CYCLE_START,
    output logic [NCH-1:0] Q
);
    logic [TW-1:0]  r_cnt;
    logic           r_pend;
    logic [TW-1:0]  w_len_m1;
    logic           w_boundary, w_swap;
    logic [NCH-1:0] w_wr, w_q;

    // Lengths 0 and 1 both collapse to a single-clock cycle.
    assign w_len_m1   = (CYCLE_LENGTH == '0) ? '0 : CYCLE_LENGTH - TW'(1);
    assign w_boundary = EN && (r_cnt >= w_len_m1);
    assign w_swap     = (r_pend || SWAP_REQ) && (!EN || w_boundary);

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_cnt  <= '0;
            r_pend <= 1'b0;
        end else begin
            r_cnt  <= (!EN || w_boundary) ? '0 : r_cnt + TW'(1);
            r_pend <= (r_pend || SWAP_REQ) && !w_swap;
        end
    end

    genvar g;
    generate
        for (g = 0; g < NCH; g++) begin : g_lane
            // Indices >= NCH match no lane, so such writes are dropped.
            assign w_wr[g] = WR_EN && (WR_CH == CHW'(g));

            fmt_chan_lane #(.TW(TW)) u_lane (
                .i_clk     (CLK),
                .i_rst_n   (RST_N),
                .i_en      (EN),
                .i_cnt     (r_cnt),
                .i_cyc_len (CYCLE_LENGTH),
                .i_lead_a  (LEAD_A),
                .i_lead_b  (LEAD_B),
                .i_trail   (TRAIL),
                .i_wr      (w_wr[g]),
                .i_wr_d    (WR_D),
                .i_wr_fmt  (WR_FMT),
                .i_wr_esel (WR_ESEL),
                .i_swap    (w_swap),
                .o_q       (w_q[g])
            );
        end
    endgenerate

    assign Q           = w_q;
    assign SWAP_PEND   = r_pend;
    assign CYCLE_START = RST_N && EN && (r_cnt == '0);
endmodule

// File: tb/tb_fmt_chan_bank.sv
// Scoreboard bench for fmt_chan_bank: stimulus queues hand-derived expectations,
// a negedge monitor pops and compares Q / CYCLE_START / SWAP_PEND.

module tb_fmt_chan_bank;
    localparam int NCH = 6;
    localparam int TW  = 10;
    localparam int CHW = 3;
    localparam logic [1:0] NRZ = 2'd0, RZ = 2'd1, R1 = 2'd2, DNRZ = 2'd3;

    logic           CLK = 1'b0;
    logic           RST_N, EN, WR_EN, WR_D, WR_ESEL, SWAP_REQ;
    logic [TW-1:0]  CYCLE_LENGTH, LEAD_A, LEAD_B, TRAIL;
    logic [CHW-1:0] WR_CH;
    logic [1:0]     WR_FMT;
    logic           SWAP_PEND, CYCLE_START;
    logic [NCH-1:0] Q;

    fmt_chan_bank #(.NCH(NCH), .TW(TW), .CHW(CHW)) dut (
        .CLK(CLK), .RST_N(RST_N), .EN(EN), .CYCLE_LENGTH(CYCLE_LENGTH),
        .LEAD_A(LEAD_A), .LEAD_B(LEAD_B), .TRAIL(TRAIL),
        .WR_EN(WR_EN), .WR_CH(WR_CH), .WR_D(WR_D), .WR_FMT(WR_FMT),
        .WR_ESEL(WR_ESEL), .SWAP_REQ(SWAP_REQ), .SWAP_PEND(SWAP_PEND),
        .CYCLE_START(CYCLE_START), .Q(Q)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        string          name;
        logic [NCH-1:0] q;
        logic           cs;
        logic           pend;
    } exp_t;

    exp_t sb[$];
    exp_t e_mon;
    int   n_chk = 0;
    int   n_pass = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h want %0h", nm, act, exp);
    endtask

    always @(negedge CLK) begin
        if (sb.size() > 0) begin
            e_mon = sb.pop_front();
            chk({e_mon.name, ".Q"},           64'(Q),           64'(e_mon.q));
            chk({e_mon.name, ".CYCLE_START"}, 64'(CYCLE_START), 64'(e_mon.cs));
            chk({e_mon.name, ".SWAP_PEND"},   64'(SWAP_PEND),   64'(e_mon.pend));
        end
    end

    task automatic push(input string nm, input logic [NCH-1:0] q, input logic cs, input logic pend);
        exp_t e;
        e.name = nm; e.q = q; e.cs = cs; e.pend = pend;
        sb.push_back(e);
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
        WR_EN = 1'b0;
        SWAP_REQ = 1'b0;
    endtask

    task automatic wr(input int ch, input logic d, input logic [1:0] fmt, input logic esel);
        WR_EN = 1'b1; WR_CH = CHW'(ch); WR_D = d; WR_FMT = fmt; WR_ESEL = esel;
    endtask

    // ch2 data per test cycle during the DNRZ toggle run: 1,0,1,0
    function automatic logic d2(input int n);
        return (n % 2 == 0);
    endfunction

    logic [NCH-1:0] eq;
    int c, n;

    initial begin
        RST_N = 1'b0; EN = 1'b0; WR_EN = 1'b0; WR_CH = '0; WR_D = 1'b0;
        WR_FMT = NRZ; WR_ESEL = 1'b0; SWAP_REQ = 1'b0;
        CYCLE_LENGTH = 10; LEAD_A = 3; LEAD_B = 5; TRAIL = 7;
        #1;
        push("reset", '0, 1'b0, 1'b0);
        step();
        step(); RST_N = 1'b1; wr(0, 1'b1, RZ, 1'b0);   push("idle0", '0, 1'b0, 1'b0);
        step(); wr(1, 1'b0, R1, 1'b0);                  push("idle1", '0, 1'b0, 1'b0);
        step(); wr(2, 1'b1, DNRZ, 1'b1);                push("idle2", '0, 1'b0, 1'b0);
        step(); SWAP_REQ = 1'b1;                        push("idle3", '0, 1'b0, 1'b0);
        step();                                         push("swap_idle", '0, 1'b0, 1'b0);

        // RZ / R1 / DNRZ toggle / swap-boundary run, CYCLE_LENGTH=10
        for (int j = 0; j < 40; j++) begin
            step();
            if (j == 0) EN = 1'b1;
            if (j % 10 == 4 && j < 30) begin
                wr(2, (j == 14), DNRZ, 1'b1);
                SWAP_REQ = 1'b1;
            end
            if (j == 9)  wr(0, 1'b0, RZ, 1'b0);
            if (j == 19) wr(6, 1'b1, NRZ, 1'b0);
            if (j == 29) wr(7, 1'b1, NRZ, 1'b0);
            eq = '0;
            if (j > 0) begin
                c = (j - 1) % 10;
                n = (j - 1) / 10;
                eq[0] = (n < 2) && (c >= 3) && (c < 7);
                eq[1] = !((c >= 3) && (c < 7));
                eq[2] = (c >= 5) ? d2(n) : ((n == 0) ? 1'b0 : d2(n - 1));
            end
            push("runA", eq, (j % 10 == 0), (j % 10 >= 5) && (j / 10 <= 2));
        end

        // TRAIL <= LEAD: RZ stuck 0, R1 stuck 1; DNRZ lead beyond cycle never captures
        step(); EN = 1'b0; LEAD_A = 5; TRAIL = 2; LEAD_B = 12; wr(0, 1'b1, RZ, 1'b0);
        push("en_off", 6'b000010, 1'b0, 1'b0);
        step(); wr(2, 1'b1, DNRZ, 1'b1);                push("en_off2", '0, 1'b0, 1'b0);
        step(); SWAP_REQ = 1'b1;                        push("en_off3", '0, 1'b0, 1'b0);
        for (int j = 0; j < 20; j++) begin
            step();
            if (j == 0) EN = 1'b1;
            push("runB", (j == 0) ? 6'b000000 : 6'b000010, (j % 10 == 0), 1'b0);
        end

        // CYCLE_LENGTH=0: one-clock cycles, lead 0 is out of range
        step(); EN = 1'b0; CYCLE_LENGTH = 0; LEAD_A = 0; LEAD_B = 0; TRAIL = 5;
        push("cl0_off", 6'b000010, 1'b0, 1'b0);
        for (int j = 0; j < 8; j++) begin
            step();
            if (j == 0) EN = 1'b1;
            push("runC", (j == 0) ? 6'b000000 : 6'b000010, 1'b1, 1'b0);
        end

        // Pending swap and nonzero Q, then asynchronous reset mid-cycle
        step(); CYCLE_LENGTH = 10;                      push("runD0", 6'b000010, 1'b1, 1'b0);
        for (int j = 1; j < 7; j++) begin
            step();
            if (j == 3) SWAP_REQ = 1'b1;
            c = j - 1;
            eq = '0;
            eq[0] = (c < 5);
            eq[1] = (c >= 5);
            eq[2] = 1'b1;
            push("runD", eq, 1'b0, (j >= 4));
        end
        step(); #1; RST_N = 1'b0;                       push("async_reset", '0, 1'b0, 1'b0);
        step(); RST_N = 1'b1;                           push("post_reset", '0, 1'b1, 1'b0);
        step();                                         push("post_reset2", '0, 1'b0, 1'b0);
        step();
        step();

        if (sb.size() != 0) begin
            n_chk++;
            $display("FAIL scoreboard_drain: got %0d left want 0", sb.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
